// File: rtl/xalu_pkg.sv
// Shared definitions for the multiply/divide unit (xalu).
// Holds the Op encodings and the default multiply/divide latencies.
// The control and pause logic import the same package, so all three
// agree on both.
package xalu_pkg;

  // Encoding of the xalu Op field.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7   // decoded as OP_NONE
  } xalu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } xalu_state_t;

  localparam int XALU_MULT_CYCLES = 5;
  localparam int XALU_DIV_CYCLES  = 10;

endpackage

// File: rtl/xalu.sv
// xalu: HI/LO register file with a multi-cycle multiply/divide model.
// The 64-bit result is computed combinationally when the instruction is
// issued and parked in a pending register. A down-counter models the
// instruction latency. HI/LO take the pending value on the edge where
// the counter reaches zero.
//
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low reset
//   A, B   : forwarded rs / rt operands
//   Op     : xalu_op_t encoding (none/mult/multu/div/divu/mthi/mtlo)
//   Start  : one-cycle issue qualifier
//   Busy   : registered; high while a mult/div is in flight
//   HI, LO : architectural HI/LO registers
module xalu
  import xalu_pkg::*;
#(
  parameter int MULT_CYCLES = XALU_MULT_CYCLES,
  parameter int DIV_CYCLES  = XALU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  xalu_op_t    op;
  xalu_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;   // cleared for divide-by-zero, so HI/LO are kept

  logic        is_signed;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_by;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign op = xalu_op_t'(Op);

  // The divide works on magnitudes and fixes the signs afterwards. This
  // keeps 0x80000000 / -1 well defined (quotient 0x80000000, remainder 0).
  // The quotient truncates toward zero, and the remainder takes the sign
  // of the dividend.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, starting
    // with these defaults, so no latches are inferred.
    is_signed = 1'b0;
    prod      = '0;
    a_neg     = 1'b0;
    b_neg     = 1'b0;
    a_mag     = '0;
    b_mag     = '0;
    div_by    = 32'd1;
    q_mag     = '0;
    r_mag     = '0;
    quo       = '0;
    rem       = '0;

    is_signed = (op == OP_MULT) || (op == OP_DIV);

    if (is_signed)
      prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    else
      prod = {32'b0, A} * {32'b0, B};

    a_neg  = is_signed & A[31];
    b_neg  = is_signed & B[31];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    // The divisor is forced to 1 when B is 0; that result is never committed.
    div_by = (B == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / div_by;
    r_mag  = a_mag % div_by;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end

  // NOTE: all state is updated with non-blocking assignments, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      Busy    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                pend_hi <= prod[63:32];
                pend_lo <= prod[31:0];
                pend_wr <= 1'b1;
                cnt     <= CNT_W'(MULT_CYCLES);
                Busy    <= 1'b1;
                state   <= S_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi <= rem;
                pend_lo <= quo;
                pend_wr <= (B != 32'd0);
                cnt     <= CNT_W'(DIV_CYCLES);
                Busy    <= 1'b1;
                state   <= S_BUSY;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          // Start is ignored here. Only the countdown and the final commit
          // take place.
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            Busy  <= 1'b0;
            state <= S_IDLE;
            if (pend_wr) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xalu.sv
// Self-checking bench for xalu. The stimulus pushes the expected
// {busy length, HI, LO} of every mult/div into a scoreboard queue. A
// monitor measures each Busy run on the falling clock edge, pops the
// queue when Busy falls, and compares. Immediate effects (reset, mthi,
// mtlo, ignored ops) are checked inline by the stimulus.
module tb_xalu;
  import xalu_pkg::*;

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  xalu dut (
    .clk   (clk),
    .reset (reset),
    .A     (a),
    .B     (b),
    .Op    (op),
    .Start (start),
    .Busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input string name, input int len, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.name = name; e.len = len; e.hi = h; e.lo = l;
    sb.push_back(e);
  endtask

  // Drives one issue. It returns 1 time unit after the Start edge, which
  // is inside the first Busy cycle for a mult/div.
  task automatic issue(input xalu_op_t o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); #1;
      if (!busy && sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout, busy=%0b pending=%0d", name, busy, sb.size());
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    int  run_len = 0;
    bit  prev = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run_len = 0;
        prev = 0;
      end else begin
        if (busy) run_len++;
        if (prev && !busy) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_busy_fall: got len %0d, expected no operation", run_len);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_busy_len"}, 64'(run_len), 64'(e.len));
            check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
            check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          end
          run_len = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    // Reset state
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    push("mult", 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
    wait_idle("mult");

    push("multu", 5, 32'h00000001, 32'hFFFFFFFE);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle("multu");

    push("div_neg7_2", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_neg7_2");

    push("div_by_zero", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(OP_DIV, 32'd5, 32'd0);
    wait_idle("div_by_zero");

    push("div_ovf", 10, 32'h00000000, 32'h80000000);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");

    push("divu", 10, 32'h00000001, 32'h7FFFFFFC);
    issue(OP_DIVU, 32'hFFFFFFF9, 32'd2);
    wait_idle("divu");

    push("div_7_neg2", 10, 32'h00000001, 32'hFFFFFFFD);
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_idle("div_7_neg2");

    // mthi while busy (3rd Busy cycle) must be ignored
    push("mult_mthi_ignored", 5, 32'h00000002, 32'h00000000);
    issue(OP_MULT, 32'h00010000, 32'h00020000);
    @(posedge clk); @(posedge clk); #1;
    op = OP_MTHI; a = 32'h1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    wait_idle("mult_mthi_ignored");

    // mtlo / mthi in IDLE
    issue(OP_MTLO, 32'hABCD, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h0000ABCD);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_hi_kept", 64'(hi), 64'h00000002);
    issue(OP_MTHI, 32'h5555, 32'd0);
    check("mthi_hi", 64'(hi), 64'h00005555);

    // none / reserved have no effect
    issue(OP_NONE, 32'hDEAD, 32'd1);
    issue(OP_RSVD, 32'hBEEF, 32'd1);
    @(posedge clk); #1;
    check("noop_busy", 64'(busy), 64'd0);
    check("noop_hilo", {hi, lo}, {32'h00005555, 32'h0000ABCD});

    // Back-to-back Starts: the second is ignored
    push("mult_b2b", 5, 32'hFFFFFFFF, 32'hFFFFFFF4);
    @(posedge clk); #1;
    op = OP_MULT; a = 32'd3; b = 32'hFFFFFFFC; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    wait_idle("mult_b2b");

    // Reset in the 4th Busy cycle of a divu aborts it
    issue(OP_DIVU, 32'd100, 32'd3);
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("abort_after_busy", 64'(busy), 64'd0);
    check("abort_after_hilo", {hi, lo}, 64'd0);

    // Start on the first edge after reset release is honoured
    reset = 1'b0;
    @(posedge clk); #1;
    push("mult_after_reset", 5, 32'h00000000, 32'd42);
    reset = 1'b1;
    op = OP_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    check("first_edge_busy", 64'(busy), 64'd1);
    wait_idle("mult_after_reset");

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
